// File: rtl/display_source_arbiter.sv
// display_source_arbiter
// Shares the 8-digit, two-page seven-segment display between the operand entry
// path (requester A) and the ALU result path (requester B). The winning value is
// captured into a display buffer. It then stays on the display for at least
// HOLD_CYCLES before another capture is granted. The block also drives the
// rotator page select, either from a dwell timer or from a manual button pulse.
//
// Optional build macro: BLANK_LEAD_EN. When it is defined, blank_mask flags the
// leading-zero digits of each captured value. When it is undefined, blank_mask
// is tied to 0 and no logic is generated for it.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   req_a, data_a   requester A level request and 32-bit value (nibble i = digit i)
//   req_b, data_b   requester B level request and 32-bit value
//   gnt_a, gnt_b    one-cycle pulse: the matching data was captured this cycle
//   auto_page_en    enable automatic page toggling
//   page_btn        debounced one-cycle pulse that toggles the page manually
//   digits          display buffer to the rotator
//   display_upper   page select to the rotator (1 = upper four digits)
//   owner           00 none, 01 A, 10 B
//   blank_mask      bit i = digit i blanked
module display_source_arbiter #(
    parameter int unsigned DWELL_CYCLES = 50000000,
    parameter int unsigned HOLD_CYCLES  = 25000000,
    parameter int unsigned CNT_W        = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [31:0] data_a,
    input  logic        req_b,
    input  logic [31:0] data_b,
    output logic        gnt_a,
    output logic        gnt_b,
    input  logic        auto_page_en,
    input  logic        page_btn,
    output logic [31:0] digits,
    output logic        display_upper,
    output logic [1:0]  owner,
    output logic [7:0]  blank_mask
);

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_A    = 2'b01;
    localparam logic [1:0] OWNER_B    = 2'b10;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        FREE = 2'b10
    } state_t;

    state_t           state, state_n;
    logic             ptr_b, ptr_b_n;        // 1: B wins the next tie
    logic             manual, manual_n;      // page was last set by page_btn
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic [CNT_W-1:0] dwell_cnt, dwell_n;
    logic             gnt_a_n, gnt_b_n;
    logic [31:0]      digits_n;
    logic             upper_n;
    logic [1:0]       owner_n;
    logic             pick_a, pick_b;
    logic             auto_act;

    // Next-state, arbitration, counters and paging
    always_comb begin
        state_n  = state;
        ptr_b_n  = ptr_b;
        manual_n = manual;
        hold_n   = hold_cnt;
        dwell_n  = dwell_cnt;
        gnt_a_n  = 1'b0;
        gnt_b_n  = 1'b0;
        digits_n = digits;
        upper_n  = display_upper;
        owner_n  = owner;
        pick_a   = 1'b0;
        pick_b   = 1'b0;
        auto_act = auto_page_en && (owner != OWNER_NONE) && (digits[31:16] != 16'h0);

        // Requests stay pending while the current value is being held
        if (state != HOLD) begin
            if (req_a && req_b) begin
                pick_a = !ptr_b;
                pick_b = ptr_b;
            end else begin
                pick_a = req_a;
                pick_b = req_b;
            end
        end

        if (state == HOLD) begin
            if (hold_cnt == HOLD_LAST) begin
                state_n = FREE;
            end else begin
                hold_n = hold_cnt + CNT_W'(1);
            end
        end

        // A capture overrides any page activity in the same cycle
        if (pick_a || pick_b) begin
            state_n  = HOLD;
            hold_n   = '0;
            dwell_n  = '0;
            upper_n  = 1'b0;
            manual_n = 1'b0;
            ptr_b_n  = pick_a;
            gnt_a_n  = pick_a;
            gnt_b_n  = pick_b;
            digits_n = pick_a ? data_a : data_b;
            owner_n  = pick_a ? OWNER_A : OWNER_B;
        end else if (page_btn && (owner != OWNER_NONE)) begin
            upper_n  = !display_upper;
            dwell_n  = '0;
            manual_n = 1'b1;
        end else if (auto_act) begin
            if (dwell_cnt == DWELL_LAST) begin
                dwell_n = '0;
                upper_n = !display_upper;
            end else begin
                dwell_n = dwell_cnt + CNT_W'(1);
            end
        end else begin
            dwell_n = '0;
            if (!manual) begin
                upper_n = 1'b0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr_b         <= 1'b0;
            manual        <= 1'b0;
            hold_cnt      <= '0;
            dwell_cnt     <= '0;
            gnt_a         <= 1'b0;
            gnt_b         <= 1'b0;
            digits        <= '0;
            display_upper <= 1'b0;
            owner         <= OWNER_NONE;
        end else begin
            state         <= state_n;
            ptr_b         <= ptr_b_n;
            manual        <= manual_n;
            hold_cnt      <= hold_n;
            dwell_cnt     <= dwell_n;
            gnt_a         <= gnt_a_n;
            gnt_b         <= gnt_b_n;
            digits        <= digits_n;
            display_upper <= upper_n;
            owner         <= owner_n;
        end
    end

`ifdef BLANK_LEAD_EN
    // Bit i set when nibbles 7..i are all zero; digit 0 is always shown
    function automatic logic [7:0] lead_mask(input logic [31:0] v);
        logic [7:0] m;
        logic       zero_above;
        m          = 8'h00;
        zero_above = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            zero_above = zero_above && (v[4*i +: 4] == 4'h0);
            m[i]       = zero_above;
        end
        return m;
    endfunction

    // Mask is recomputed on capture only, alongside digits
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_mask <= 8'h00;
        end else if (gnt_a_n || gnt_b_n) begin
            blank_mask <= lead_mask(digits_n);
        end
    end
`else
    assign blank_mask = 8'h00;
`endif

endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed bench for display_source_arbiter with DWELL_CYCLES=4, HOLD_CYCLES=3.
module tb_display_source_arbiter;

    localparam logic [31:0] VAL_A = 32'h00001234;
    localparam logic [31:0] VAL_B = 32'h12345678;
    localparam int NVEC = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_a = 1'b0;
    logic [31:0] data_a = VAL_A;
    logic        req_b = 1'b0;
    logic [31:0] data_b = VAL_B;
    logic        gnt_a, gnt_b;
    logic        auto_page_en = 1'b0;
    logic        page_btn = 1'b0;
    logic [31:0] digits;
    logic        display_upper;
    logic [1:0]  owner;
    logic [7:0]  blank_mask;

    int checks   = 0;
    int failures = 0;

    display_source_arbiter #(
        .DWELL_CYCLES(4),
        .HOLD_CYCLES (3),
        .CNT_W       (26)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_a        (req_a),
        .data_a       (data_a),
        .req_b        (req_b),
        .data_b       (data_b),
        .gnt_a        (gnt_a),
        .gnt_b        (gnt_b),
        .auto_page_en (auto_page_en),
        .page_btn     (page_btn),
        .digits       (digits),
        .display_upper(display_upper),
        .owner        (owner),
        .blank_mask   (blank_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ra;
        logic        rb;
        logic        aut;
        logic        btn;
        logic        ga;
        logic        gb;
        logic [31:0] dig;
        logic        up;
        logic [1:0]  own;
        logic [7:0]  mask;   // expected mask when leading-zero blanking is built in
    } vec_t;

    vec_t vec [NVEC];

    function automatic vec_t mk(input logic r, input logic ra, input logic rb,
                                input logic au, input logic bt, input logic ga,
                                input logic gb, input logic [31:0] dg, input logic up,
                                input logic [1:0] ow, input logic [7:0] mk_mask);
        vec_t v;
        v.rst = r;  v.ra = ra; v.rb = rb; v.aut = au; v.btn = bt;
        v.ga  = ga; v.gb = gb; v.dig = dg; v.up = up; v.own = ow; v.mask = mk_mask;
        return v;
    endfunction

    function automatic logic [7:0] eff_mask(input logic [7:0] m);
`ifdef BLANK_LEAD_EN
        return m;
`else
        return 8'h00 & m;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt_a(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick();
            if (gnt_a) seen = 1'b1;
        end
    endtask

    initial begin
        bit seen;

        //               rst ra rb au bt | ga gb digits up own   mask
        vec[0]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 2'b00, 8'h00);
        vec[1]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 2'b00, 8'h00);
        vec[2]  = mk(0, 1, 1, 1, 0, 1, 0, VAL_A, 0, 2'b01, 8'hF0);  // tie: A first
        vec[3]  = mk(0, 0, 1, 1, 0, 0, 0, VAL_A, 0, 2'b01, 8'hF0);  // hold 1
        vec[4]  = mk(0, 0, 1, 1, 0, 0, 0, VAL_A, 0, 2'b01, 8'hF0);  // hold 2
        vec[5]  = mk(0, 0, 1, 1, 0, 0, 0, VAL_A, 0, 2'b01, 8'hF0);  // to FREE
        vec[6]  = mk(0, 0, 1, 1, 0, 0, 1, VAL_B, 0, 2'b10, 8'h00);  // pending B granted
        vec[7]  = mk(0, 0, 0, 1, 0, 0, 0, VAL_B, 0, 2'b10, 8'h00);
        vec[8]  = mk(0, 0, 0, 1, 0, 0, 0, VAL_B, 0, 2'b10, 8'h00);
        vec[9]  = mk(0, 0, 0, 1, 0, 0, 0, VAL_B, 0, 2'b10, 8'h00);
        vec[10] = mk(0, 0, 0, 1, 0, 0, 0, VAL_B, 1, 2'b10, 8'h00);  // dwell wrap
        vec[11] = mk(0, 0, 0, 1, 0, 0, 0, VAL_B, 1, 2'b10, 8'h00);
        vec[12] = mk(0, 0, 0, 1, 1, 0, 0, VAL_B, 0, 2'b10, 8'h00);  // button toggles
        vec[13] = mk(0, 0, 0, 1, 0, 0, 0, VAL_B, 0, 2'b10, 8'h00);
        vec[14] = mk(0, 0, 0, 1, 0, 0, 0, VAL_B, 0, 2'b10, 8'h00);
        vec[15] = mk(0, 0, 0, 1, 0, 0, 0, VAL_B, 0, 2'b10, 8'h00);
        vec[16] = mk(0, 0, 0, 1, 0, 0, 0, VAL_B, 1, 2'b10, 8'h00);  // dwell restarted
        vec[17] = mk(0, 1, 0, 1, 1, 1, 0, VAL_A, 0, 2'b01, 8'hF0);  // capture beats button
        vec[18] = mk(0, 0, 0, 0, 1, 0, 0, VAL_A, 1, 2'b01, 8'hF0);  // button in HOLD
        vec[19] = mk(0, 0, 0, 0, 0, 0, 0, VAL_A, 1, 2'b01, 8'hF0);  // manual page kept
        vec[20] = mk(0, 0, 0, 1, 0, 0, 0, VAL_A, 1, 2'b01, 8'hF0);
        vec[21] = mk(0, 0, 1, 1, 0, 0, 1, VAL_B, 0, 2'b10, 8'h00);
        vec[22] = mk(0, 1, 0, 1, 0, 0, 0, VAL_B, 0, 2'b10, 8'h00);  // A ignored in HOLD
        vec[23] = mk(1, 1, 0, 0, 0, 0, 0, 32'h0, 0, 2'b00, 8'h00);  // reset mid-HOLD
        vec[24] = mk(0, 1, 0, 0, 0, 1, 0, VAL_A, 0, 2'b01, 8'hF0);
        vec[25] = mk(0, 0, 0, 0, 0, 0, 0, VAL_A, 0, 2'b01, 8'hF0);
        vec[26] = mk(0, 0, 0, 0, 0, 0, 0, VAL_A, 0, 2'b01, 8'hF0);
        vec[27] = mk(0, 0, 0, 0, 0, 0, 0, VAL_A, 0, 2'b01, 8'hF0);
        vec[28] = mk(0, 1, 1, 0, 0, 0, 1, VAL_B, 0, 2'b10, 8'h00);  // tie: B after A
        vec[29] = mk(0, 1, 0, 0, 0, 0, 0, VAL_B, 0, 2'b10, 8'h00);

        for (int i = 0; i < NVEC; i++) begin
            rst          = vec[i].rst;
            req_a        = vec[i].ra;
            req_b        = vec[i].rb;
            auto_page_en = vec[i].aut;
            page_btn     = vec[i].btn;
            tick();
            chk($sformatf("row%0d_gnt_a", i), 32'(gnt_a), 32'(vec[i].ga));
            chk($sformatf("row%0d_gnt_b", i), 32'(gnt_b), 32'(vec[i].gb));
            chk($sformatf("row%0d_digits", i), digits, vec[i].dig);
            chk($sformatf("row%0d_upper", i), 32'(display_upper), 32'(vec[i].up));
            chk($sformatf("row%0d_owner", i), 32'(owner), 32'(vec[i].own));
            chk($sformatf("row%0d_mask", i), 32'(blank_mask), 32'(eff_mask(vec[i].mask)));
        end

        // Capture 0x50 once the B hold expires, then watch paging stay on page 0
        req_a        = 1'b1;
        data_a       = 32'h00000050;
        auto_page_en = 1'b1;
        wait_gnt_a(seen);
        chk("cap50_gnt_seen", 32'(seen), 32'd1);
        chk("cap50_digits", digits, 32'h00000050);
        chk("cap50_owner", 32'(owner), 32'd1);
        chk("cap50_mask", 32'(blank_mask), 32'(eff_mask(8'b11111100)));
        req_a = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("low_only_upper_c%0d", c), 32'(display_upper), 32'd0);
        end

        // Capture of all zeros keeps digit 0 visible
        req_a  = 1'b1;
        data_a = 32'h00000000;
        wait_gnt_a(seen);
        chk("cap0_gnt_seen", 32'(seen), 32'd1);
        chk("cap0_digits", digits, 32'h00000000);
        chk("cap0_mask", 32'(blank_mask), 32'(eff_mask(8'b11111110)));
        req_a = 1'b0;
        tick();
        chk("cap0_gnt_pulse_end", 32'(gnt_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
